// File: rtl/dcache_controller.sv
// dcache_controller: miss sequencer for a direct-mapped write-back write-allocate data cache
// Ports: core request (MemRead, MemWrite, Addr) -> Stall; array lookup (LineValid, LineDirty,
//   TagHit, VictimTag) -> array writes (TagWrite, NewDirty, DataWe, DataSrcMem, WordSel);
//   word-wide memory port (MemReq, MemWe, MemAddr, MemAck).
// Define DCACHE_PERF_EN to add the HitCount/MissCount outputs.
module dcache_controller #(
  parameter int ADDR_W = 32,
  parameter int INDEX_W = 6,
  parameter int LINE_WORDS = 4,
  localparam int WC_W = $clog2(LINE_WORDS),
  localparam int OFF_W = WC_W + 2,
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              LineValid,
  input  logic              LineDirty,
  input  logic              TagHit,
  input  logic [TAG_W-1:0]  VictimTag,
  output logic              Stall,
  output logic              TagWrite,
  output logic              NewDirty,
  output logic              DataWe,
  output logic              DataSrcMem,
  output logic [WC_W-1:0]   WordSel,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]       HitCount,
  output logic [31:0]       MissCount
`endif
);
  typedef enum logic [1:0] {IDLE, WB, REFILL, UPDATE} state_t;
  state_t state, state_nxt;
  logic [WC_W-1:0] word_cnt;
  logic [ADDR_W-OFF_W-1:0] req_line;
  logic req, hit, miss, wr_hit, last, unused_ok;
  assign req = MemRead | MemWrite;
  assign hit = req & LineValid & TagHit;
  assign miss = req & ~hit;
  assign wr_hit = hit & MemWrite;
  assign last = word_cnt == WC_W'(LINE_WORDS - 1);
  assign unused_ok = ^Addr[1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // word_cnt wraps naturally because LINE_WORDS is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_cnt <= '0;
      req_line <= '0;
    end else if (state == IDLE) begin
      word_cnt <= '0;
      if (miss) req_line <= Addr[ADDR_W-1:OFF_W];
    end else if ((state == WB || state == REFILL) && MemAck) begin
      word_cnt <= word_cnt + 1'b1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = miss ? (LineValid && LineDirty ? WB : REFILL) : IDLE;
      WB:      state_nxt = MemAck && last ? REFILL : WB;
      REFILL:  state_nxt = MemAck && last ? UPDATE : REFILL;
      default: state_nxt = IDLE;
    endcase
  end
  // outputs are gated by rst_n so everything reads 0 while reset is held
  always_comb begin
    Stall = 1'b0;
    TagWrite = 1'b0;
    NewDirty = 1'b0;
    DataWe = 1'b0;
    DataSrcMem = 1'b0;
    WordSel = '0;
    MemReq = 1'b0;
    MemWe = 1'b0;
    MemAddr = '0;
    if (rst_n)
      case (state)
        IDLE: begin
          Stall = miss;
          DataWe = wr_hit;
          TagWrite = wr_hit;
          NewDirty = wr_hit;
          WordSel = wr_hit ? Addr[OFF_W-1:2] : '0;
        end
        WB: begin
          Stall = 1'b1;
          MemReq = 1'b1;
          MemWe = 1'b1;
          WordSel = word_cnt;
          MemAddr = {VictimTag, req_line[INDEX_W-1:0], word_cnt, 2'b00};
        end
        REFILL: begin
          Stall = 1'b1;
          MemReq = 1'b1;
          DataWe = MemAck;
          DataSrcMem = MemAck;
          WordSel = word_cnt;
          MemAddr = {req_line, word_cnt, 2'b00};
        end
        default: begin
          Stall = 1'b1;
          TagWrite = 1'b1;
        end
      endcase
  end
`ifdef DCACHE_PERF_EN
  // the IDLE cycle right after UPDATE is the replay of a counted miss
  logic replay;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      replay <= 1'b0;
      HitCount <= '0;
      MissCount <= '0;
    end else begin
      replay <= state == UPDATE;
      if (state == IDLE && hit && !replay) HitCount <= HitCount + 1'b1;
      if (state == IDLE && miss) MissCount <= MissCount + 1'b1;
    end
`endif
endmodule
